// File: rtl/display_scan_ctrl.sv
// Scan controller for a bank of common-anode 7-segment digits that share one
// segment bus. Each digit gets a slot of DIV cycles. The first BLANK cycles of
// every slot turn all anodes off to prevent ghosting between digits. Display
// data is double-buffered, so the shown value changes only between frames.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BLANK | divcnt < BLANK: all anodes off, segments off
// ST_SHOW  | divcnt >= BLANK: drive anode idx (if enabled) and its digit
module display_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 2
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [4*DIGITS-1:0]   iData,
  input  logic                  iLoad,
  input  logic [DIGITS-1:0]     iDigitEn,
  output logic [6:0]            oSeg,
  output logic [DIGITS-1:0]     oAn,
  output logic                  oFrame
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  logic [CW-1:0]         divcnt, nxt_divcnt;
  logic [IW-1:0]         idx, nxt_idx;
  logic [4*DIGITS-1:0]   shadow, nxt_shadow;
  logic [4*DIGITS-1:0]   pending;
  logic                  pend_v;
  logic                  frame_end;
  state_t                nxt_state;
  logic [3:0]            digit;
  logic [DIGITS-1:0]     an_d;
  logic [6:0]            seg_d;
  logic                  frame_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Slot and digit counters for the next cycle.
  always_comb begin
    nxt_divcnt = divcnt + 1'b1;
    nxt_idx    = idx;
    frame_end  = (divcnt == DIV_LAST) && (idx == IDX_LAST);
    if (divcnt == DIV_LAST) begin
      nxt_divcnt = '0;
      nxt_idx    = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Shadow takes new data only across a frame boundary. A load in the
  // boundary cycle itself is the newest, so it overrides the pending buffer.
  always_comb begin
    nxt_shadow = shadow;
    if (frame_end) begin
      if (iLoad)
        nxt_shadow = iData;
      else if (pend_v)
        nxt_shadow = pending;
    end
  end

  // Output values for the next cycle. They are computed from next-state
  // values so the registered outputs line up with the live divcnt and idx.
  always_comb begin
    nxt_state = (nxt_divcnt < BLANK_C) ? ST_BLANK : ST_SHOW;
    digit     = nxt_shadow[{nxt_idx, 2'b00} +: 4];
    an_d      = '1;
    seg_d     = 7'b1111111;
    if (nxt_state == ST_SHOW && iDigitEn[nxt_idx]) begin
      an_d  = ~(DIGITS'(1) << nxt_idx);
      seg_d = seg_decode(digit);
    end
    frame_d = (nxt_divcnt == DIV_LAST) && (nxt_idx == IDX_LAST);
  end

  // State, buffers and registered outputs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      divcnt  <= '0;
      idx     <= '0;
      shadow  <= '0;
      pending <= '0;
      pend_v  <= 1'b0;
      oAn     <= '1;
      oSeg    <= 7'b1111111;
      oFrame  <= 1'b0;
    end else begin
      divcnt <= nxt_divcnt;
      idx    <= nxt_idx;
      shadow <= nxt_shadow;
      if (frame_end) begin
        pend_v <= 1'b0;
      end else if (iLoad) begin
        pending <= iData;
        pend_v  <= 1'b1;
      end
      oAn    <= an_d;
      oSeg   <= seg_d;
      oFrame <= frame_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with DIGITS=4, DIV=8, BLANK=2. Expected outputs
// come from a cycle-indexed model. The slot, position and frame are derived
// from the cycle number. The displayed word is the last load seen in the
// previous frame.
module tb_display_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic        iClk;
  logic        iRst;
  logic [15:0] iData;
  logic        iLoad;
  logic [3:0]  iDigitEn;
  logic [6:0]  oSeg;
  logic [3:0]  oAn;
  logic        oFrame;

  int          errors;
  int          checks;
  int          t;
  logic [15:0] shadow_m;
  logic [15:0] last_load;
  bit          have_load;
  logic [3:0]  en_m;

  display_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
    .iClk(iClk), .iRst(iRst), .iData(iData), .iLoad(iLoad),
    .iDigitEn(iDigitEn), .oSeg(oSeg), .oAn(oAn), .oFrame(oFrame)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
            7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
    return tbl[d];
  endfunction

  function automatic logic [3:0] exp_an();
    int pos  = t % DIV;
    int slot = (t / DIV) % DIGITS;
    if (pos < BLANK || !en_m[slot]) return 4'hF;
    return ~(4'b0001 << slot);
  endfunction

  function automatic logic [6:0] exp_seg();
    int pos  = t % DIV;
    int slot = (t / DIV) % DIGITS;
    if (pos < BLANK || !en_m[slot]) return 7'b1111111;
    return seg_of(shadow_m[slot*4 +: 4]);
  endfunction

  function automatic logic exp_frame();
    return (t % FRAME) == FRAME - 1;
  endfunction

  task automatic reset_dut();
    iRst  = 1'b1;
    iLoad = 1'b0;
    @(posedge iClk);
    #1;
    iRst      = 1'b0;
    t         = 0;
    shadow_m  = '0;
    have_load = 1'b0;
  endtask

  task automatic next_cycle();
    if (iLoad) begin
      last_load = iData;
      have_load = 1'b1;
    end
    if (t % FRAME == FRAME - 1) begin
      if (have_load) shadow_m = last_load;
      have_load = 1'b0;
    end
    @(posedge iClk);
    #1;
    t++;
    iLoad = 1'b0;
  endtask

  task automatic test_reset();
    iDigitEn = 4'b1111;
    en_m     = 4'b1111;
    reset_dut();
    @(negedge iClk);
    checks++;
    if (oAn !== 4'b1111 || oSeg !== 7'b1111111 || oFrame !== 1'b0) begin
      errors++;
      $display("FAIL reset_state oAn=%b oSeg=%b oFrame=%b required 1111 1111111 0", oAn, oSeg, oFrame);
    end
    next_cycle();
    @(negedge iClk);
    checks++;
    if (oAn !== 4'b1111 || oSeg !== 7'b1111111) begin
      errors++;
      $display("FAIL reset_blank1 oAn=%b oSeg=%b required 1111 1111111", oAn, oSeg);
    end
  endtask

  task automatic test_scan();
    iDigitEn = 4'b1111;
    en_m     = 4'b1111;
    reset_dut();
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge iClk);
      checks++;
      if (oAn !== exp_an() || oSeg !== exp_seg() || oFrame !== exp_frame()) begin
        errors++;
        $display("FAIL scan t=%0d oAn=%b exp=%b oSeg=%b exp=%b oFrame=%b exp=%b",
                 t, oAn, exp_an(), oSeg, exp_seg(), oFrame, exp_frame());
      end
      if (t == 5) begin
        checks++;
        if (oAn !== 4'b1110 || oSeg !== 7'b1000000) begin
          errors++;
          $display("FAIL scan_slot0 oAn=%b oSeg=%b required 1110 1000000", oAn, oSeg);
        end
      end
      if (t == 12) begin
        checks++;
        if (oAn !== 4'b1101) begin
          errors++;
          $display("FAIL scan_slot1 oAn=%b required 1101", oAn);
        end
      end
      if (t == 31 || t == 63) begin
        checks++;
        if (oFrame !== 1'b1) begin
          errors++;
          $display("FAIL scan_frame t=%0d oFrame=%b required 1", t, oFrame);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_load();
    iDigitEn = 4'b1111;
    en_m     = 4'b1111;
    reset_dut();
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (t == 5) begin
        iLoad = 1'b1;
        iData = 16'h4321;
      end
      @(negedge iClk);
      checks++;
      if (oAn !== exp_an() || oSeg !== exp_seg() || oFrame !== exp_frame()) begin
        errors++;
        $display("FAIL load t=%0d oAn=%b exp=%b oSeg=%b exp=%b oFrame=%b exp=%b",
                 t, oAn, exp_an(), oSeg, exp_seg(), oFrame, exp_frame());
      end
      if (t == 20 || t == 36 || t == 44 || t == 52 || t == 60) begin
        logic [3:0] an_r;
        logic [6:0] seg_r;
        case (t)
          20:      begin an_r = 4'b1011; seg_r = 7'b1000000; end
          36:      begin an_r = 4'b1110; seg_r = 7'b1111001; end
          44:      begin an_r = 4'b1101; seg_r = 7'b0100100; end
          52:      begin an_r = 4'b1011; seg_r = 7'b0110000; end
          default: begin an_r = 4'b0111; seg_r = 7'b0011001; end
        endcase
        checks++;
        if (oAn !== an_r || oSeg !== seg_r) begin
          errors++;
          $display("FAIL load_digit t=%0d oAn=%b oSeg=%b required %b %b", t, oAn, oSeg, an_r, seg_r);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_digit_en();
    iDigitEn = 4'b0101;
    en_m     = 4'b0101;
    reset_dut();
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge iClk);
      checks++;
      if (oAn !== exp_an() || oSeg !== exp_seg() || oFrame !== exp_frame()) begin
        errors++;
        $display("FAIL digit_en t=%0d oAn=%b exp=%b oSeg=%b exp=%b oFrame=%b exp=%b",
                 t, oAn, exp_an(), oSeg, exp_seg(), oFrame, exp_frame());
      end
      if ((t % FRAME) / DIV == 1 || (t % FRAME) / DIV == 3) begin
        checks++;
        if (oAn !== 4'b1111 || oSeg !== 7'b1111111) begin
          errors++;
          $display("FAIL digit_off t=%0d oAn=%b oSeg=%b required 1111 1111111", t, oAn, oSeg);
        end
      end
      if (t == 20) begin
        checks++;
        if (oAn !== 4'b1011 || oSeg !== 7'b1000000) begin
          errors++;
          $display("FAIL digit_on2 oAn=%b oSeg=%b required 1011 1000000", oAn, oSeg);
        end
      end
      if (t == 31 || t == 63) begin
        checks++;
        if (oFrame !== 1'b1) begin
          errors++;
          $display("FAIL digit_en_frame t=%0d oFrame=%b required 1", t, oFrame);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_blank_code();
    iDigitEn = 4'b1111;
    en_m     = 4'b1111;
    reset_dut();
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (t == 3) begin
        iLoad = 1'b1;
        iData = 16'h9A80;
      end
      @(negedge iClk);
      checks++;
      if (oAn !== exp_an() || oSeg !== exp_seg() || oFrame !== exp_frame()) begin
        errors++;
        $display("FAIL blank_code t=%0d oAn=%b exp=%b oSeg=%b exp=%b oFrame=%b exp=%b",
                 t, oAn, exp_an(), oSeg, exp_seg(), oFrame, exp_frame());
      end
      if (t == 52) begin
        checks++;
        if (oAn !== 4'b1011 || oSeg !== 7'b1111111) begin
          errors++;
          $display("FAIL code_A_lit oAn=%b oSeg=%b required 1011 1111111", oAn, oSeg);
        end
      end
      if (t == 60) begin
        checks++;
        if (oAn !== 4'b0111 || oSeg !== 7'b0010000) begin
          errors++;
          $display("FAIL code_9 oAn=%b oSeg=%b required 0111 0010000", oAn, oSeg);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    iDigitEn = 4'b1111;
    en_m     = 4'b1111;
    reset_dut();
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (t == 31) begin iLoad = 1'b1; iData = 16'h1111; end
      if (t == 40) begin iLoad = 1'b1; iData = 16'h2222; end
      if (t == 50) begin iLoad = 1'b1; iData = 16'h3333; end
      @(negedge iClk);
      checks++;
      if (oAn !== exp_an() || oSeg !== exp_seg() || oFrame !== exp_frame()) begin
        errors++;
        $display("FAIL back_to_back t=%0d oAn=%b exp=%b oSeg=%b exp=%b oFrame=%b exp=%b",
                 t, oAn, exp_an(), oSeg, exp_seg(), oFrame, exp_frame());
      end
      if (t == 36 || t == 60) begin
        checks++;
        if (oSeg !== 7'b1111001) begin
          errors++;
          $display("FAIL coincident_load t=%0d oSeg=%b required 1111001", t, oSeg);
        end
      end
      if (t == 68 || t == 92) begin
        checks++;
        if (oSeg !== 7'b0110000) begin
          errors++;
          $display("FAIL last_load_wins t=%0d oSeg=%b required 0110000", t, oSeg);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_mid_reset();
    iDigitEn = 4'b1111;
    en_m     = 4'b1111;
    reset_dut();
    for (int c = 0; c <= 20; c++) begin
      if (t == 5) begin iLoad = 1'b1; iData = 16'h5555; end
      @(negedge iClk);
      checks++;
      if (oAn !== exp_an() || oSeg !== exp_seg() || oFrame !== exp_frame()) begin
        errors++;
        $display("FAIL mid_reset_pre t=%0d oAn=%b exp=%b oSeg=%b exp=%b oFrame=%b exp=%b",
                 t, oAn, exp_an(), oSeg, exp_seg(), oFrame, exp_frame());
      end
      if (c < 20) next_cycle();
    end
    reset_dut();
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge iClk);
      checks++;
      if (oAn !== exp_an() || oSeg !== exp_seg() || oFrame !== exp_frame()) begin
        errors++;
        $display("FAIL mid_reset t=%0d oAn=%b exp=%b oSeg=%b exp=%b oFrame=%b exp=%b",
                 t, oAn, exp_an(), oSeg, exp_seg(), oFrame, exp_frame());
      end
      if (t == 0) begin
        checks++;
        if (oAn !== 4'b1111 || oSeg !== 7'b1111111 || oFrame !== 1'b0) begin
          errors++;
          $display("FAIL mid_reset_out oAn=%b oSeg=%b oFrame=%b required 1111 1111111 0", oAn, oSeg, oFrame);
        end
      end
      if (t == 4 || t == 36) begin
        checks++;
        if (oAn !== 4'b1110 || oSeg !== 7'b1000000) begin
          errors++;
          $display("FAIL pending_discard t=%0d oAn=%b oSeg=%b required 1110 1000000", t, oAn, oSeg);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      iDigitEn = 4'($urandom);
      en_m     = iDigitEn;
      reset_dut();
      for (int c = 0; c < 3 * FRAME; c++) begin
        if (t % DIV == 0 && $urandom_range(3) == 0) begin
          iDigitEn = 4'($urandom);
          en_m     = iDigitEn;
        end
        if ($urandom_range(5) == 0) begin
          iLoad = 1'b1;
          iData = 16'($urandom);
        end
        @(negedge iClk);
        checks++;
        if (oAn !== exp_an() || oSeg !== exp_seg() || oFrame !== exp_frame()) begin
          errors++;
          $display("FAIL random r=%0d t=%0d oAn=%b exp=%b oSeg=%b exp=%b oFrame=%b exp=%b",
                   r, t, oAn, exp_an(), oSeg, exp_seg(), oFrame, exp_frame());
        end
        next_cycle();
      end
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    t         = 0;
    iRst      = 1'b1;
    iLoad     = 1'b0;
    iData     = '0;
    iDigitEn  = 4'b1111;
    en_m      = 4'b1111;
    shadow_m  = '0;
    last_load = '0;
    have_load = 1'b0;
    test_reset();
    test_scan();
    test_load();
    test_digit_en();
    test_blank_code();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
